// File: rtl/pixel_write_fifo_if.sv
// Renderer-to-FIFO pixel bus and FIFO-to-framebuffer write bus.
// The slave modport is the FIFO's view; master is the environment's.
interface pixel_write_fifo_if;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot;
  logic        in_ready;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;

  modport slave (
    input  in_x,
    input  in_y,
    input  in_colour,
    input  in_plot,
    output in_ready,
    output fb_addr,
    output fb_data,
    output fb_we,
    input  fb_ready
  );

  modport master (
    output in_x,
    output in_y,
    output in_colour,
    output in_plot,
    input  in_ready,
    input  fb_addr,
    input  fb_data,
    input  fb_we,
    output fb_ready
  );
endinterface

// File: rtl/pixel_write_fifo.sv
// Pixel write FIFO: range-checks renderer pixels, linearises the address
// and queues {addr, colour} for the framebuffer with valid/ready on both sides.
module pixel_write_fifo #(
  parameter int DEPTH = 8,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic               clk,
  input  logic               resetn,
  pixel_write_fifo_if.slave  bus,
  output logic [6:0]         level,
  output logic [15:0]        drop_count,
  output logic               stall_seen
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  colour;
  } pix_t;

  pix_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [6:0]    lvl_q, lvl_d;
  logic [15:0]   drop_q, drop_d;
  logic          stall_q, stall_d;

  logic          in_range;
  logic          push_hs;
  logic          push;
  logic          pop;
  logic [14:0]   lin_addr;

  assign bus.in_ready = lvl_q < 7'(DEPTH);
  assign bus.fb_we    = lvl_q != 7'd0;
  assign bus.fb_addr  = mem_q[rd_q].addr;
  assign bus.fb_data  = mem_q[rd_q].colour;

  assign in_range = ({1'b0, bus.in_x} < 9'(SCR_W)) &&
                    ({1'b0, bus.in_y} < 8'(SCR_H));

  // Address is formed before storage so the framebuffer side is a plain read.
  assign lin_addr = 15'(bus.in_y) * 15'(SCR_W) + 15'(bus.in_x);

  assign push_hs = bus.in_plot & bus.in_ready;
  assign push    = push_hs & in_range;
  assign pop     = bus.fb_we & bus.fb_ready;

  assign level      = lvl_q;
  assign drop_count = drop_q;
  assign stall_seen = stall_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    drop_d  = drop_q;
    stall_d = stall_q;
    if (push) begin
      wr_d = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    lvl_d = lvl_q + 7'(push) - 7'(pop);
    if (push_hs && !in_range && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
    if (bus.in_plot && !bus.in_ready) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      drop_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      drop_q  <= drop_d;
      stall_q <= stall_d;
    end
  end

  // Storage is not reset; the head is only meaningful while fb_we is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= '{addr: lin_addr, colour: bus.in_colour};
    end
  end

endmodule
